// File: rtl/fuzz_slice_scan.sv
// Snapshots a packed input vector and scans it one slice per cycle, accumulating
// a below-threshold count, a running parity and an equality flag into out_0.
module fuzz_slice_scan #(
  parameter int NUM_IN = 3,
  parameter int SLICE_W = 2,
  parameter logic [SLICE_W-1:0] THRESH = SLICE_W'(1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [NUM_IN*32-1:0]  in_,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           out_0
);

  localparam int NSLICES = NUM_IN * 32 / SLICE_W;
  localparam int IDX_W = $clog2(NSLICES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  state_t                state;
  logic [NUM_IN*32-1:0]  snap;
  logic [IDX_W-1:0]      idx;
  logic [15:0]           cnt;
  logic                  par;
  logic                  eq;

  logic [SLICE_W-1:0]    slice;
  logic [15:0]           cnt_nxt;
  logic                  par_nxt;
  logic                  eq_nxt;

  // The snapshot is shifted down each cycle, so the current slice is always its low bits.
  assign slice   = snap[SLICE_W-1:0];
  assign cnt_nxt = cnt + 16'(THRESH > slice);
  assign par_nxt = par ^ (^slice);
  assign eq_nxt  = eq | (slice == THRESH);

  assign busy = (state == SCAN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      done  <= 1'b0;
      out_0 <= '0;
      snap  <= '0;
      idx   <= '0;
      cnt   <= '0;
      par   <= 1'b0;
      eq    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            snap  <= in_;
            idx   <= '0;
            cnt   <= '0;
            par   <= 1'b0;
            eq    <= 1'b0;
            state <= SCAN;
          end
        end
        SCAN: begin
          // Abort wins even on the final slice, so no result is published.
          if (abort) begin
            state <= IDLE;
          end else begin
            snap <= snap >> SLICE_W;
            idx  <= idx + IDX_W'(1);
            cnt  <= cnt_nxt;
            par  <= par_nxt;
            eq   <= eq_nxt;
            if (idx == LAST_IDX) begin
              out_0 <= {14'd0, eq_nxt, par_nxt, cnt_nxt};
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fuzz_slice_scan.md
Name: fuzz_slice_scan

Overview:
- Sequential, parametrised successor to the flat-vector comparison harness blocks.
- Snapshots a packed multi-word input vector and scans it one SLICE_W-bit slice per cycle.
- Per slice it accumulates an unsigned less-than count against a constant threshold, a running XOR parity, and an equality flag.
- Reports a packed 32-bit result word with a start/busy/done handshake; serves as a multi-cycle CXXRTL-vs-reference regression target.

Parameters:
- NUM_IN, 3, number of 32-bit input words packed into in_ (1..2048).
- SLICE_W, 2, slice width in bits; must divide NUM_IN*32 (1..16).
- THRESH, 1, unsigned constant compared against each slice; width SLICE_W.
- NSLICES (localparam), NUM_IN*32/SLICE_W.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin scan; sampled only in IDLE.
- abort  in  1  cancel scan; sampled only in SCAN.
- in_  in  NUM_IN*32  packed input; word i occupies bits [32*i+31:32*i].
- busy  out  1  high while in SCAN.
- done  out  1  one-cycle pulse when a result is written.
- out_0  out  32  result word, held until the next completion.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE; busy=0, done=0, out_0=0.
  - Slice index, count, parity and eq cleared; snapshot cleared.
  - Reset mid-SCAN discards the scan with no done pulse.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - start=1 at edge E0: snapshot <- in_, idx <- 0, cnt <- 0, par <- 0, eq <- 0, state -> SCAN.
  - abort is ignored in IDLE; start+abort together: start wins.
- SCAN, edges E1..E_NSLICES, edge Ek processes slice s = snap[(k-1)*SLICE_W +: SLICE_W]:
  - cnt += (THRESH > s), unsigned.
  - par ^= ^s.
  - eq |= (s == THRESH).
  - At E_NSLICES:
    - out_0[15:0] <- final cnt.
    - out_0[16] <- final par.
    - out_0[17] <- final eq.
    - out_0[31:18] <- 0.
    - state -> DONE.
  - Final values include the last slice's contribution.
- Snapshot isolation: in_ changes after E0 do not affect the result.
- start in SCAN/DONE is ignored; it does not queue.
- abort=1 at any SCAN edge, including E_NSLICES:
  - state -> IDLE; out_0 unchanged; no done pulse.
  - abort beats completion.
- DONE: done=1 for exactly one cycle; next edge -> IDLE unconditionally. A start during DONE is ignored.
- busy=1 exactly while state==SCAN (combinational from state, or registered equivalently).
- done is high in the cycle after E_NSLICES.
- Latency: done is observed NSLICES edges after the start edge; a new start is accepted at the edge after DONE.
- Widths:
  - cnt is 16 bits; NSLICES <= 65535 guarantees no overflow.
  - All comparisons are unsigned at SLICE_W bits.
- out_0 is not cleared on start; it holds the previous result throughout a scan.

Test Plan:
- Defaults, in_0=0x00020000, in_1=in_2=0, pulse start:
  - Slice 8 = 2'b10, all other slices 0, count = 47.
  - done after 48 edges; out_0=0x0001002F; busy high for 48 cycles.
- All-zero in_: out_0=0x00000030 (count 48, parity 0, eq 0).
- Parity/eq check:
  - in_0=0x00000001: out_0=0x0003002F (slice0=01 gives eq=1 and parity 1).
  - All-ones in_: out_0=0x00000000.
- Snapshot check: start with in_0=0x00020000, then drive in_0=0xFFFFFFFF from E1 on. Result is still 0x0001002F.
- Busy-start check: hold start high through a whole scan. Exactly one done pulse per accepted start; the next scan begins at the edge after DONE.
- Abort and reset:
  - abort at E20: no done, out_0 keeps its prior value 0x0001002F, state IDLE.
  - abort exactly at E48: no done.
  - rst at E10: out_0=0, busy=0, done=0.
  - A new scan after reset completes normally.
